booth_ctrl: RTL and testbench

BOOTH_CTRL -- requirements
Module: booth_ctrl

---
 rtl/booth_ctrl.sv | 113 +++++++++++
 tb/tb_booth_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// Control sequencer for a radix-2 Booth multiplier: a Moore FSM that steps the
// A/Q/M datapath through clear, load, N_ITER evaluate/add-sub/shift rounds and readout.
module booth_ctrl #(
  parameter int N_ITER = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic sub,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);

  localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    LOAD_Q,
    LOAD_M,
    EVAL,
    ADDSUB,
    SHIFT,
    OUT_A,
    OUT_Q,
    DONE
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic            sub_lat;
  logic            nxt_sub;

  // Next-state and add/subtract decision; q0/q_m1 only matter in EVAL.
  always_comb begin
    nxt     = state;
    nxt_sub = sub_lat;
    case (state)
      IDLE:   if (start) nxt = INIT;
      INIT:   nxt = LOAD_Q;
      LOAD_Q: nxt = LOAD_M;
      LOAD_M: nxt = EVAL;
      EVAL: begin
        case ({q0, q_m1})
          2'b10: begin
            nxt     = ADDSUB;
            nxt_sub = 1'b1;
          end
          2'b01: begin
            nxt     = ADDSUB;
            nxt_sub = 1'b0;
          end
          default: nxt = SHIFT;
        endcase
      end
      ADDSUB: nxt = SHIFT;
      SHIFT:  nxt = (cnt == LAST) ? OUT_A : EVAL;
      OUT_A:  nxt = OUT_Q;
      OUT_Q:  nxt = DONE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sub_lat <= 1'b0;
      c0      <= 1'b0;
      c1      <= 1'b0;
      c2      <= 1'b0;
      c3      <= 1'b0;
      sub     <= 1'b0;
      c4      <= 1'b0;
      c5      <= 1'b0;
      c6      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      sub_lat <= nxt_sub;
      if (state == INIT) begin
        cnt <= '0;
      end else if (state == SHIFT) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
      c0   <= (nxt == INIT);
      c1   <= (nxt == LOAD_Q);
      c2   <= (nxt == LOAD_M);
      c3   <= (nxt == ADDSUB);
      sub  <= (nxt == ADDSUB) && nxt_sub;
      c4   <= (nxt == SHIFT);
      c5   <= (nxt == OUT_A);
      c6   <= (nxt == OUT_Q);
      busy <= (nxt != IDLE);
      done <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: expected per-cycle control traces are built from the
// Booth step rules (clear, load, per-iteration evaluate/add-sub/shift, readout).
module tb_booth_ctrl;

  localparam int N  = 8;
  localparam int PW = 2 * N;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic q0;
  logic q_m1;
  logic c0, c1, c2, c3, sub, c4, c5, c6, busy, done;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  booth_ctrl #(.N_ITER(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .q0   (q0),
    .q_m1 (q_m1),
    .c0   (c0),
    .c1   (c1),
    .c2   (c2),
    .c3   (c3),
    .sub  (sub),
    .c4   (c4),
    .c5   (c5),
    .c6   (c6),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  wire [6:0] cvec = {c6, c5, c4, c3, c2, c1, c0};
  wire [9:0] outs = {busy, done, sub, cvec};

  typedef struct {
    logic [6:0] c;
    logic       sub;
    logic       done;
    bit         is_eval;
    bit         is_shift;
    int         iter;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [PW-1:0] pats;
    bit            hold;
    int            pulse_iter;
    int            exp_done;
    int            exp_c3;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Structural invariants every cycle, including during reset.
  always @(negedge clk) begin
    chk("onehot_c", {31'd0, $onehot0(cvec)}, 32'd1);
    chk("sub_only_with_c3", {31'd0, sub & ~c3}, 32'd0);
    chk("done_implies_busy", {31'd0, done & ~busy}, 32'd0);
  end

  function automatic void add_step(input logic [6:0] c, input logic s, input logic d,
                                   input bit ev, input bit sh, input int it);
    exp_t e;
    e.c = c; e.sub = s; e.done = d; e.is_eval = ev; e.is_shift = sh; e.iter = it;
    exp_q.push_back(e);
  endfunction

  // One Booth multiplication, one entry per clock cycle after the start edge.
  function automatic void build_trace(input logic [PW-1:0] pats);
    logic [1:0] p;
    exp_q.delete();
    add_step(7'b0000001, 1'b0, 1'b0, 0, 0, 0);
    add_step(7'b0000010, 1'b0, 1'b0, 0, 0, 0);
    add_step(7'b0000100, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      p = pats[2*i +: 2];
      add_step(7'b0000000, 1'b0, 1'b0, 1, 0, i + 1);
      if (p == 2'b10) add_step(7'b0001000, 1'b1, 1'b0, 0, 0, i + 1);
      if (p == 2'b01) add_step(7'b0001000, 1'b0, 1'b0, 0, 0, i + 1);
      add_step(7'b0010000, 1'b0, 1'b0, 0, 1, i + 1);
    end
    add_step(7'b0100000, 1'b0, 1'b0, 0, 0, 0);
    add_step(7'b1000000, 1'b0, 1'b0, 0, 0, 0);
    add_step(7'b0000000, 1'b0, 1'b1, 0, 0, 0);
  endfunction

  function automatic int count_addsub(input logic [PW-1:0] pats);
    int n = 0;
    for (int i = 0; i < N; i++) if (pats[2*i] != pats[2*i+1]) n++;
    return n;
  endfunction

  // Entered #1 after a clock edge. Returns #1 after an edge.
  task automatic run_txn(input logic [PW-1:0] pats, input bit hold, input int pulse_iter,
                         input bit junk_start, input int abort_iter,
                         output int done_edge, output int n_c3);
    int e1;
    int n_done;
    exp_t e;
    build_trace(pats);
    done_edge = -1;
    n_c3 = 0;
    n_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    e1 = edge_cnt;
    if (!hold) start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      chk("trace", {22'd0, outs}, {22'd0, 1'b1, e.done, e.sub, e.c});
      if (done) begin
        n_done++;
        done_edge = edge_cnt - e1 + 1;
      end
      if (c3) n_c3++;
      if (abort_iter >= 0 && e.is_shift && e.iter == abort_iter) return;
      if (e.is_eval) {q0, q_m1} = pats[2*(e.iter-1) +: 2];
      else {q0, q_m1} = 2'($urandom);
      if (!hold) begin
        if (e.done) start = 1'b0;
        else start = (e.is_eval && e.iter == pulse_iter) ||
                     (junk_start && $urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
    end
    chk("single_done", n_done, 1);
    chk("idle_after_done", {22'd0, outs}, 32'd0);
  endtask

  vec_t vecs[7];
  int   de;
  int   nc;
  logic [PW-1:0] rp;

  initial begin
    vecs[0] = '{16'h0000, 0, 0, 22, 0};
    vecs[1] = '{16'hAAAA, 0, 0, 30, 8};
    vecs[2] = '{16'h9999, 0, 0, 30, 8};
    vecs[3] = '{16'hFFFF, 0, 0, 22, 0};
    vecs[4] = '{16'h00A5, 0, 5, 26, 4};
    vecs[5] = '{16'h0000, 0, 5, 22, 0};
    vecs[6] = '{16'h5555, 0, 0, 30, 8};

    rst = 1'b1; start = 1'b0; q0 = 1'b0; q_m1 = 1'b0;
    #1;
    chk("reset_outputs", {22'd0, outs}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {q0, q_m1} = 2'($urandom);
      @(posedge clk); #1;
      chk("idle_quiet", {22'd0, outs}, 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].pats, vecs[v].hold, vecs[v].pulse_iter, 0, -1, de, nc);
      chk("vec_done_edge", de, vecs[v].exp_done);
      chk("vec_c3_count", nc, vecs[v].exp_c3);
    end

    // start held high: DONE at 22, IDLE at 23, next INIT at 24.
    run_txn(16'h0000, 1, 0, 0, -1, de, nc);
    chk("hold_done_edge", de, 22);
    run_txn(16'h0000, 0, 0, 0, -1, de, nc);
    chk("hold_second_done", de, 22);

    // Asynchronous reset during SHIFT of iteration 3.
    run_txn(16'h00A6, 0, 0, 0, 3, de, nc);
    chk("pre_reset_shift", {25'd0, cvec}, 32'h10);
    #2 rst = 1'b1; start = 1'b1;
    #1;
    chk("async_reset_outputs", {22'd0, outs}, 32'd0);
    @(posedge clk); #1;
    chk("held_reset_outputs", {22'd0, outs}, 32'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {22'd0, outs}, 32'd0);
    run_txn(16'h00A6, 0, 0, 0, -1, de, nc);
    chk("post_reset_done", de, 22 + count_addsub(16'h00A6));

    for (int r = 0; r < 8; r++) begin
      rp = PW'($urandom);
      run_txn(rp, 0, 0, 1, -1, de, nc);
      chk("rand_done_edge", de, 22 + count_addsub(rp));
      chk("rand_c3_count", nc, count_addsub(rp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
